// File: rtl/ip_sdram_checker.sv
// SDRAM self-test engine: fills a window with one of four patterns, reads it back and compares.
// Latency: start -> first sdram_wr 2 cycles; last compare -> done 1 cycle; read timeout after TIMEOUT cycles.
// Backpressure: every request waits for sdram_busy low; each read waits for sdram_rdata_en or the timeout.
//
// Ports: clk/n_reset (async active-low); start/mode/continuous/base_address are latched at start
// acceptance; sdram_* is the byte-address request port of the controller; running/done/pass,
// error_count (saturating), pass_count (wrapping), first_err_* and timeout_seen are registered status.
module ip_sdram_checker #(
    parameter int          ADDR_WIDTH = 23,
    parameter int          DATA_WIDTH = 8,
    parameter int          TEST_WORDS = 256,
    parameter int          TIMEOUT    = 64,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  continuous,
    input  logic [ADDR_WIDTH-1:0] base_address,
    output logic                  sdram_rd,
    output logic                  sdram_wr,
    input  logic                  sdram_busy,
    output logic [ADDR_WIDTH-1:0] sdram_address,
    output logic [DATA_WIDTH-1:0] sdram_wdata,
    input  logic [DATA_WIDTH-1:0] sdram_rdata,
    input  logic                  sdram_rdata_en,
    output logic                  running,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           error_count,
    output logic [15:0]           pass_count,
    output logic [ADDR_WIDTH-1:0] first_err_address,
    output logic [DATA_WIDTH-1:0] first_err_expected,
    output logic [DATA_WIDTH-1:0] first_err_actual,
    output logic                  timeout_seen
);

    localparam int STEP  = DATA_WIDTH / 8;
    localparam int IDX_W = (TEST_WORDS > 1) ? $clog2(TEST_WORDS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TEST_WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic                  cont_q, cont_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;       // address of the current word
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  guard_q, guard_d;
    logic [TMO_W-1:0]      timer_q, timer_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;         // expected data of the outstanding read
    logic                  sdram_rd_q, sdram_rd_d;
    logic                  sdram_wr_q, sdram_wr_d;
    logic [ADDR_WIDTH-1:0] sdram_address_q, sdram_address_d;
    logic [DATA_WIDTH-1:0] sdram_wdata_q, sdram_wdata_d;
    logic                  running_q, running_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [15:0]           error_count_q, error_count_d;
    logic [15:0]           pass_count_q, pass_count_d;
    logic [ADDR_WIDTH-1:0] first_err_address_q, first_err_address_d;
    logic [DATA_WIDTH-1:0] first_err_expected_q, first_err_expected_d;
    logic [DATA_WIDTH-1:0] first_err_actual_q, first_err_actual_d;
    logic                  timeout_seen_q, timeout_seen_d;

    logic [DATA_WIDTH-1:0] pattern;
    logic [15:0]           lfsr_next;
    logic                  word_done;
    logic                  err_event;
    logic [DATA_WIDTH-1:0] err_actual;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting towards bit 0
    assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_comb begin
        pattern = '0;
        case (mode_q)
            2'd0:    pattern = addr_q[DATA_WIDTH-1:0];
            2'd1:    pattern = ~addr_q[DATA_WIDTH-1:0];
            2'd2:    pattern = lfsr_q[DATA_WIDTH-1:0];
            default: pattern = index_q[0] ? {(DATA_WIDTH/2){2'b10}} : {(DATA_WIDTH/2){2'b01}};
        endcase
    end

    always_comb begin
        state_d              = state_q;
        mode_d               = mode_q;
        cont_d               = cont_q;
        base_d               = base_q;
        index_d              = index_q;
        addr_d               = addr_q;
        lfsr_d               = lfsr_q;
        guard_d              = guard_q;
        timer_d              = timer_q;
        exp_d                = exp_q;
        sdram_rd_d           = 1'b0;
        sdram_wr_d           = 1'b0;
        sdram_address_d      = sdram_address_q;
        sdram_wdata_d        = sdram_wdata_q;
        running_d            = running_q;
        done_d               = done_q;
        pass_d               = pass_q;
        error_count_d        = error_count_q;
        pass_count_d         = pass_count_q;
        first_err_address_d  = first_err_address_q;
        first_err_expected_d = first_err_expected_q;
        first_err_actual_d   = first_err_actual_q;
        timeout_seen_d       = timeout_seen_q;
        word_done            = 1'b0;
        err_event            = 1'b0;
        err_actual           = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d               = mode;
                    cont_d               = continuous;
                    base_d               = base_address;
                    addr_d               = base_address;
                    index_d              = '0;
                    lfsr_d               = LFSR_SEED;
                    error_count_d        = '0;
                    first_err_address_d  = '0;
                    first_err_expected_d = '0;
                    first_err_actual_d   = '0;
                    timeout_seen_d       = 1'b0;
                    running_d            = 1'b1;
                    done_d               = 1'b0;
                    pass_d               = 1'b0;
                    state_d              = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (!sdram_busy) begin
                    sdram_wr_d      = 1'b1;
                    sdram_address_d = addr_q;
                    sdram_wdata_d   = pattern;
                    guard_d         = 1'b1;
                    state_d         = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                // The controller may not raise busy until the cycle after the request.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!sdram_busy) begin
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        addr_d  = base_q;
                        lfsr_d  = LFSR_SEED;
                        state_d = S_RD_REQ;
                    end else begin
                        index_d = index_q + 1'b1;
                        addr_d  = addr_q + ADDR_WIDTH'(STEP);
                        lfsr_d  = lfsr_next;
                        state_d = S_WR_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (!sdram_busy) begin
                    sdram_rd_d      = 1'b1;
                    sdram_address_d = addr_q;
                    exp_d           = pattern;
                    timer_d         = '0;
                    state_d         = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Data arriving on the expiry cycle wins over the timeout.
                if (sdram_rdata_en) begin
                    word_done  = 1'b1;
                    err_event  = (sdram_rdata != exp_q);
                    err_actual = sdram_rdata;
                end else if (timer_q == TMO_LAST) begin
                    word_done      = 1'b1;
                    err_event      = 1'b1;
                    timeout_seen_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end

                if (err_event) begin
                    // error_count never returns to zero once incremented, so zero marks the first error.
                    if (error_count_q == 16'd0) begin
                        first_err_address_d  = sdram_address_q;
                        first_err_expected_d = exp_q;
                        first_err_actual_d   = err_actual;
                    end
                    if (error_count_q != 16'hFFFF) begin
                        error_count_d = error_count_q + 16'd1;
                    end
                end

                if (word_done) begin
                    if (index_q == LAST_IDX) begin
                        pass_count_d = pass_count_q + 16'd1;
                        index_d      = '0;
                        addr_d       = base_q;
                        lfsr_d       = LFSR_SEED;
                        if (cont_q) begin
                            state_d = S_WR_REQ;
                        end else begin
                            state_d   = S_DONE;
                            running_d = 1'b0;
                            done_d    = 1'b1;
                            pass_d    = (error_count_d == 16'd0);
                        end
                    end else begin
                        index_d = index_q + 1'b1;
                        addr_d  = addr_q + ADDR_WIDTH'(STEP);
                        lfsr_d  = lfsr_next;
                        state_d = S_RD_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q              <= S_IDLE;
            mode_q               <= '0;
            cont_q               <= 1'b0;
            base_q               <= '0;
            index_q              <= '0;
            addr_q               <= '0;
            lfsr_q               <= '0;
            guard_q              <= 1'b0;
            timer_q              <= '0;
            exp_q                <= '0;
            sdram_rd_q           <= 1'b0;
            sdram_wr_q           <= 1'b0;
            sdram_address_q      <= '0;
            sdram_wdata_q        <= '0;
            running_q            <= 1'b0;
            done_q               <= 1'b0;
            pass_q               <= 1'b0;
            error_count_q        <= '0;
            pass_count_q         <= '0;
            first_err_address_q  <= '0;
            first_err_expected_q <= '0;
            first_err_actual_q   <= '0;
            timeout_seen_q       <= 1'b0;
        end else begin
            state_q              <= state_d;
            mode_q               <= mode_d;
            cont_q               <= cont_d;
            base_q               <= base_d;
            index_q              <= index_d;
            addr_q               <= addr_d;
            lfsr_q               <= lfsr_d;
            guard_q              <= guard_d;
            timer_q              <= timer_d;
            exp_q                <= exp_d;
            sdram_rd_q           <= sdram_rd_d;
            sdram_wr_q           <= sdram_wr_d;
            sdram_address_q      <= sdram_address_d;
            sdram_wdata_q        <= sdram_wdata_d;
            running_q            <= running_d;
            done_q               <= done_d;
            pass_q               <= pass_d;
            error_count_q        <= error_count_d;
            pass_count_q         <= pass_count_d;
            first_err_address_q  <= first_err_address_d;
            first_err_expected_q <= first_err_expected_d;
            first_err_actual_q   <= first_err_actual_d;
            timeout_seen_q       <= timeout_seen_d;
        end
    end

    assign sdram_rd           = sdram_rd_q;
    assign sdram_wr           = sdram_wr_q;
    assign sdram_address      = sdram_address_q;
    assign sdram_wdata        = sdram_wdata_q;
    assign running            = running_q;
    assign done               = done_q;
    assign pass               = pass_q;
    assign error_count        = error_count_q;
    assign pass_count         = pass_count_q;
    assign first_err_address  = first_err_address_q;
    assign first_err_expected = first_err_expected_q;
    assign first_err_actual   = first_err_actual_q;
    assign timeout_seen       = timeout_seen_q;

endmodule

// File: tb/tb_ip_sdram_checker.sv
module tb_ip_sdram_checker;

    localparam int          AW   = 23;
    localparam int          DW   = 8;
    localparam int          NW   = 24;
    localparam int          TMO  = 64;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          start;
    logic [1:0]    mode;
    logic          continuous;
    logic [AW-1:0] base_address;
    logic          sdram_rd, sdram_wr, sdram_busy, sdram_rdata_en;
    logic [AW-1:0] sdram_address;
    logic [DW-1:0] sdram_wdata, sdram_rdata;
    logic          running, done, pass, timeout_seen;
    logic [15:0]   error_count, pass_count;
    logic [AW-1:0] first_err_address;
    logic [DW-1:0] first_err_expected, first_err_actual;

    always #5 clk = ~clk;

    ip_sdram_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TEST_WORDS(NW), .TIMEOUT(TMO), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .mode(mode), .continuous(continuous),
        .base_address(base_address), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
        .sdram_busy(sdram_busy), .sdram_address(sdram_address), .sdram_wdata(sdram_wdata),
        .sdram_rdata(sdram_rdata), .sdram_rdata_en(sdram_rdata_en), .running(running),
        .done(done), .pass(pass), .error_count(error_count), .pass_count(pass_count),
        .first_err_address(first_err_address), .first_err_expected(first_err_expected),
        .first_err_actual(first_err_actual), .timeout_seen(timeout_seen)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int start_cyc, last_en_cyc, done_cyc;
    int exp_pc = 0;

    // memory / controller model state
    bit            busy_rand, no_resp, invert, corrupt_en;
    logic [AW-1:0] corrupt_addr;
    logic [7:0]    mem [int];
    logic [AW-1:0] wr_addr_q[$];
    logic [7:0]    wr_data_q[$];
    int            wr_cyc_q[$];
    logic [AW-1:0] rd_addr_q[$];
    int            rd_cyc_q[$];
    bit            pending, proto_bad, done_prev, rd_prev;
    int            lat, since_wr;
    logic [AW-1:0] pend_addr;

    // Reference pattern: word idx of a window at base, computed directly from the pattern rules.
    function automatic logic [7:0] model_word(input logic [1:0] m, input logic [AW-1:0] base, input int idx);
        logic [AW-1:0] a;
        logic [15:0]   l;
        a = base + AW'(idx);
        l = SEED;
        for (int k = 0; k < idx; k++) l = {^(l & 16'h002D), l[15:1]};
        case (m)
            2'd0:    return a[7:0];
            2'd1:    return ~a[7:0];
            2'd2:    return l[7:0];
            default: return (idx % 2 == 1) ? 8'hAA : 8'h55;
        endcase
    endfunction

    // Behavioural controller + bus monitor, all activity on the falling edge.
    initial begin
        sdram_busy = 1'b0; sdram_rdata = '0; sdram_rdata_en = 1'b0;
        pending = 0; proto_bad = 0; done_prev = 0; rd_prev = 0; since_wr = 100;
        forever begin
            @(negedge clk);
            cyc++;
            since_wr++;
            if (!n_reset) pending = 0;
            if (sdram_wr && sdram_rd) proto_bad = 1;
            if (sdram_rd && rd_prev) proto_bad = 1;
            rd_prev = sdram_rd;
            if (sdram_wr) begin
                if (since_wr < 3) proto_bad = 1;
                since_wr = 0;
                wr_addr_q.push_back(sdram_address);
                wr_data_q.push_back(sdram_wdata);
                wr_cyc_q.push_back(cyc);
                mem[int'(sdram_address)] = (corrupt_en && sdram_address == corrupt_addr) ? 8'h00 : sdram_wdata;
            end
            if (done && !done_prev) done_cyc = cyc;
            done_prev = done;
            sdram_rdata_en = 1'b0;
            if (pending) begin
                lat--;
                if (lat == 0) begin
                    pending = 0;
                    sdram_rdata = mem.exists(int'(pend_addr)) ? mem[int'(pend_addr)] : 8'h00;
                    if (invert) sdram_rdata = ~sdram_rdata;
                    sdram_rdata_en = 1'b1;
                    last_en_cyc = cyc;
                end
            end
            if (sdram_rd) begin
                if (pending) proto_bad = 1;
                rd_addr_q.push_back(sdram_address);
                rd_cyc_q.push_back(cyc);
                if (!no_resp) begin
                    pending = 1;
                    lat = $urandom_range(1, 5);
                    pend_addr = sdram_address;
                end
            end
            sdram_busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    task automatic clear_model(input bit br, input bit nr, input bit inv, input bit ce, input logic [AW-1:0] ca);
        @(negedge clk); #1;
        busy_rand = br; no_resp = nr; invert = inv; corrupt_en = ce; corrupt_addr = ca;
        mem.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
        pending = 0; proto_bad = 0; done_cyc = -1; last_en_cyc = -1;
    endtask

    task automatic do_start(input logic [1:0] m, input bit c, input logic [AW-1:0] base);
        @(negedge clk); #1;
        mode = m; continuous = c; base_address = base; start = 1'b1; start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0; mode = 2'($urandom); continuous = 1'($urandom); base_address = AW'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20000) begin @(negedge clk); #1; n++; end
        if (!done) begin
            tests++; fails++;
            $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic seq_errors(input logic [1:0] m, input logic [AW-1:0] base, output int bad);
        bad = 0;
        foreach (wr_addr_q[i]) begin
            if (wr_addr_q[i] !== base + AW'(i % NW)) bad++;
            if (wr_data_q[i] !== model_word(m, base, i % NW)) bad++;
        end
        foreach (rd_addr_q[i]) if (rd_addr_q[i] !== base + AW'(i % NW)) bad++;
    endtask

    task automatic test_reset();
        n_reset = 1'b0; start = 1'b0; mode = '0; continuous = 1'b0; base_address = '0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({sdram_rd, sdram_wr, running, done, pass, timeout_seen} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b required 000000", {sdram_rd, sdram_wr, running, done, pass, timeout_seen});
        end
        tests++;
        if ({error_count, pass_count, sdram_address, sdram_wdata} !== '0) begin
            fails++; $display("FAIL reset_counters: err=%h pc=%h addr=%h wd=%h required all 0", error_count, pass_count, sdram_address, sdram_wdata);
        end
        tests++;
        if ({first_err_address, first_err_expected, first_err_actual} !== '0) begin
            fails++; $display("FAIL reset_first_err: %h/%h/%h required 0", first_err_address, first_err_expected, first_err_actual);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_mode0();
        int bad;
        clear_model(0, 0, 0, 0, '0);
        do_start(2'd0, 1'b0, '0);
        wait_done();
        exp_pc++;
        seq_errors(2'd0, '0, bad);
        tests++;
        if (bad != 0 || wr_addr_q.size() != NW || rd_addr_q.size() != NW) begin
            fails++; $display("FAIL mode0_seq: bad=%0d writes=%0d reads=%0d required 0/%0d/%0d", bad, wr_addr_q.size(), rd_addr_q.size(), NW, NW);
        end
        tests++;
        if (wr_cyc_q.size() == 0 || wr_cyc_q[0] - start_cyc != 2) begin
            fails++; $display("FAIL start_latency: first write %0d cycles after start, required 2", wr_cyc_q.size() ? wr_cyc_q[0] - start_cyc : -1);
        end
        tests++;
        if (done_cyc - last_en_cyc != 1) begin
            fails++; $display("FAIL done_latency: %0d cycles, required 1", done_cyc - last_en_cyc);
        end
        tests++;
        if ({done, pass, running} !== 3'b110 || error_count !== 16'd0 || pass_count !== 16'(exp_pc)) begin
            fails++; $display("FAIL mode0_status: done/pass/run=%b err=%0d pc=%0d required 110/0/%0d", {done, pass, running}, error_count, pass_count, exp_pc);
        end
        tests++;
        if (proto_bad) begin
            fails++; $display("FAIL mode0_protocol: bus protocol violation seen, required none");
        end
    endtask

    task automatic test_random_patterns();
        int bad;
        logic [AW-1:0] b;
        for (int m = 1; m < 4; m++) begin
            b = AW'($urandom);
            clear_model(1, 0, 0, 0, '0);
            do_start(2'(m), 1'b0, b);
            wait_done();
            exp_pc++;
            seq_errors(2'(m), b, bad);
            tests++;
            if (bad != 0 || pass !== 1'b1 || error_count !== 16'd0 || pass_count !== 16'(exp_pc) || proto_bad) begin
                fails++; $display("FAIL pattern_m%0d: bad=%0d pass=%b err=%0d pc=%0d proto=%b required 0/1/0/%0d/0", m, bad, pass, error_count, pass_count, proto_bad, exp_pc);
            end
        end
    endtask

    task automatic test_lfsr_fault();
        logic [7:0] e;
        e = model_word(2'd2, '0, 16);
        clear_model(1, 0, 0, 1, AW'(16));
        do_start(2'd2, 1'b0, '0);
        wait_done();
        exp_pc++;
        tests++;
        if (error_count !== ((e != 8'h00) ? 16'd1 : 16'd0) || pass !== (e == 8'h00)) begin
            fails++; $display("FAIL lfsr_fault_count: err=%0d pass=%b, expected word %h", error_count, pass, e);
        end
        tests++;
        if (e != 8'h00 && (first_err_address !== AW'(16) || first_err_expected !== e || first_err_actual !== 8'h00)) begin
            fails++; $display("FAIL lfsr_first_err: addr=%h exp=%h act=%h required 000010/%h/00", first_err_address, first_err_expected, first_err_actual, e);
        end
    endtask

    task automatic test_invert();
        logic [AW-1:0] b;
        b = AW'($urandom);
        clear_model(1, 0, 1, 0, '0);
        do_start(2'd1, 1'b0, b);
        wait_done();
        exp_pc++;
        tests++;
        if (error_count !== 16'(NW) || pass !== 1'b0 || timeout_seen !== 1'b0) begin
            fails++; $display("FAIL invert_count: err=%0d pass=%b to=%b required %0d/0/0", error_count, pass, timeout_seen, NW);
        end
        tests++;
        if (first_err_address !== b || first_err_expected !== ~b[7:0] || first_err_actual !== b[7:0]) begin
            fails++; $display("FAIL invert_first_err: %h/%h/%h required %h/%h/%h", first_err_address, first_err_expected, first_err_actual, b, ~b[7:0], b[7:0]);
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        clear_model(0, 1, 0, 0, '0);
        do_start(2'd0, 1'b0, AW'($urandom));
        wait_done();
        exp_pc++;
        // each read waits TMO cycles, then one cycle to re-issue from RD_REQ
        for (int i = 1; i < rd_cyc_q.size(); i++) if (rd_cyc_q[i] - rd_cyc_q[i-1] != TMO + 1) bad++;
        tests++;
        if (bad != 0 || rd_cyc_q.size() != NW) begin
            fails++; $display("FAIL timeout_spacing: %0d bad gaps, %0d reads, required 0/%0d", bad, rd_cyc_q.size(), NW);
        end
        tests++;
        if (error_count !== 16'(NW) || timeout_seen !== 1'b1 || pass !== 1'b0 || first_err_actual !== 8'h00) begin
            fails++; $display("FAIL timeout_status: err=%0d to=%b pass=%b act=%h required %0d/1/0/00", error_count, timeout_seen, pass, first_err_actual, NW);
        end
    endtask

    task automatic test_start_ignored();
        int bad, n = 0;
        logic [AW-1:0] b;
        b = AW'($urandom);
        clear_model(0, 0, 0, 0, '0);
        do_start(2'd0, 1'b0, b);
        while (rd_addr_q.size() < 3 && n < 5000) begin @(negedge clk); #1; n++; end
        // DUT is in RD_WAIT here: a read was just seen and its data is at least a cycle away
        mode = 2'd3; continuous = 1'b1; base_address = b + AW'(100); start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done();
        exp_pc++;
        seq_errors(2'd0, b, bad);
        tests++;
        if (bad != 0 || rd_addr_q.size() != NW || wr_addr_q.size() != NW || pass !== 1'b1 || error_count !== 16'd0) begin
            fails++; $display("FAIL start_ignored: bad=%0d reads=%0d writes=%0d pass=%b err=%0d required 0/%0d/%0d/1/0", bad, rd_addr_q.size(), wr_addr_q.size(), pass, error_count, NW, NW);
        end
    endtask

    task automatic test_wrap();
        int bad;
        logic [AW-1:0] b;
        b = 23'h7FFFF0;
        clear_model(0, 0, 0, 0, '0);
        do_start(2'd0, 1'b0, b);
        wait_done();
        exp_pc++;
        seq_errors(2'd0, b, bad);
        tests++;
        if (bad != 0 || wr_addr_q.size() != NW || wr_addr_q[15] !== 23'h7FFFFF || wr_addr_q[16] !== 23'h000000 || pass !== 1'b1) begin
            fails++; $display("FAIL addr_wrap: bad=%0d pass=%b required 0/1", bad, pass);
        end
    endtask

    task automatic test_continuous_reset();
        int bad, n = 0;
        clear_model(1, 0, 0, 0, '0);
        do_start(2'd3, 1'b1, AW'($urandom));
        while (pass_count !== 16'(exp_pc + 3) && n < 20000) begin @(negedge clk); #1; n++; end
        tests++;
        if (pass_count !== 16'(exp_pc + 3) || running !== 1'b1 || done !== 1'b0 || error_count !== 16'd0) begin
            fails++; $display("FAIL continuous: pc=%0d run=%b done=%b err=%0d required %0d/1/0/0", pass_count, running, done, error_count, exp_pc + 3);
        end
        n = 0;
        while (!sdram_wr && n < 1000) begin @(negedge clk); #1; n++; end
        tests++;
        if (sdram_wr !== 1'b1) begin
            fails++; $display("FAIL continuous_write_wait: no write seen, required one");
        end
        n_reset = 1'b0;
        #1;
        tests++;
        if ({sdram_rd, sdram_wr, running, done, pass, timeout_seen} !== 6'b0 ||
            {error_count, pass_count, sdram_address, sdram_wdata, first_err_address} !== '0) begin
            fails++; $display("FAIL mid_reset: flags=%b pc=%0d addr=%h wd=%h required all 0",
                {sdram_rd, sdram_wr, running, done, pass, timeout_seen}, pass_count, sdram_address, sdram_wdata);
        end
        exp_pc = 0;
        @(negedge clk); #1;
        n_reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        tests++;
        if (sdram_wr !== 1'b0 || running !== 1'b0) begin
            fails++; $display("FAIL post_reset_idle: wr=%b run=%b required 0/0", sdram_wr, running);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_random_patterns();
        test_lfsr_fault();
        test_invert();
        test_timeout();
        test_start_ignored();
        test_wrap();
        test_continuous_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
